// File: rtl/pyramid_level_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pyramid_pkg
// Shared types and default widths for the pyramid level sequencer.
//   state_e       : sequencer FSM states
//   level_desc_t  : packed level descriptor (index, width, height, last) laid
//                   out at the default widths, for host-side packing of the
//                   descriptor stream
// ---------------------------------------------------------------------------
package pyramid_pkg;

  localparam int COORD_BITS_DEF = 16;
  localparam int LEVEL_BITS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic [LEVEL_BITS_DEF-1:0] index;
    logic [COORD_BITS_DEF-1:0] width;
    logic [COORD_BITS_DEF-1:0] height;
    logic                      last;
  } level_desc_t;

endpackage

// File: rtl/pyramid_level_sequencer_if.sv
// ---------------------------------------------------------------------------
// pyramid_level_sequencer_if
// Host-facing bundle of the pyramid level sequencer.
//   master : host side  (drives start/base dims/min_dim/lvl_ready)
//   slave  : sequencer  (drives busy, level descriptor handshake, done,
//                        level_count)
// ---------------------------------------------------------------------------
interface pyramid_level_sequencer_if #(
  parameter int COORD_BITS = 16,
  parameter int LEVEL_BITS = 4
);

  logic                  start;
  logic [COORD_BITS-1:0] base_width;
  logic [COORD_BITS-1:0] base_height;
  logic [COORD_BITS-1:0] min_dim;
  logic                  busy;
  logic                  lvl_valid;
  logic                  lvl_ready;
  logic [LEVEL_BITS-1:0] lvl_index;
  logic [COORD_BITS-1:0] lvl_width;
  logic [COORD_BITS-1:0] lvl_height;
  logic                  lvl_last;
  logic                  done;
  logic [LEVEL_BITS:0]   level_count;

  modport master (
    output start, base_width, base_height, min_dim, lvl_ready,
    input  busy, lvl_valid, lvl_index, lvl_width, lvl_height, lvl_last,
           done, level_count
  );

  modport slave (
    input  start, base_width, base_height, min_dim, lvl_ready,
    output busy, lvl_valid, lvl_index, lvl_width, lvl_height, lvl_last,
           done, level_count
  );

endinterface

// File: rtl/pyramid_level_sequencer_calc.sv
// ---------------------------------------------------------------------------
// DimensionCalculator_4_5
// Computes out = (in-1)*4/5 + 1 with a bit-serial restoring divide by 5.
// Latency depends on the operand: leading zeros of the dividend are skipped,
// so one iteration is spent per significant dividend bit, plus one load cycle
// and one output cycle. in_valid_i is accepted only while idle.
//   clk, reset_n           : clock, async active-low reset
//   in_valid_i / in_dim_i  : operand strobe and value (in_dim_i >= 1)
//   out_valid_o / out_dim_o: one-cycle result strobe and value
// ---------------------------------------------------------------------------
module DimensionCalculator_4_5 #(
  parameter int COORD_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid_i,
  input  logic [COORD_BITS-1:0] in_dim_i,
  output logic                  out_valid_o,
  output logic [COORD_BITS-1:0] out_dim_o
);

  localparam int DW = COORD_BITS + 2;
  localparam int CW = $clog2(DW + 1);

  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         div_q, div_d;
  logic [COORD_BITS-1:0] quo_q, quo_d;
  logic [2:0]            rem_q, rem_d;
  logic                  out_valid_q, out_valid_d;
  logic [COORD_BITS-1:0] out_dim_q, out_dim_d;

  logic [DW-1:0]         dividend;
  logic [CW-1:0]         lead_zeros;
  logic [3:0]            rem_shift;

  always_comb begin
    dividend   = {in_dim_i - 1'b1, 2'b00};
    // Highest set bit wins because later iterations overwrite earlier ones.
    lead_zeros = CW'(DW);
    for (int i = 0; i < DW; i++) begin
      if (dividend[i]) lead_zeros = CW'(DW - 1 - i);
    end
    rem_shift   = {rem_q, div_q[DW-1]};

    busy_d      = busy_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    out_valid_d = 1'b0;
    out_dim_d   = out_dim_q;

    if (!busy_q) begin
      if (in_valid_i) begin
        busy_d = 1'b1;
        div_d  = dividend << lead_zeros;
        cnt_d  = CW'(DW) - lead_zeros;
        rem_d  = '0;
        quo_d  = '0;
      end
    end else if (cnt_q == '0) begin
      busy_d      = 1'b0;
      out_valid_d = 1'b1;
      out_dim_d   = quo_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
      div_d = div_q << 1;
      // Quotient always fits COORD_BITS since (in-1)*4/5 < in.
      if (rem_shift >= 4'd5) begin
        rem_d = 3'(rem_shift - 4'd5);
        quo_d = {quo_q[COORD_BITS-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[2:0];
        quo_d = {quo_q[COORD_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_dim_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_dim_q   <= out_dim_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_dim_o   = out_dim_q;

endmodule

// File: rtl/pyramid_level_sequencer.sv
// ---------------------------------------------------------------------------
// pyramid_level_sequencer
// Walks an image pyramid: starting from the base dimensions, each level is
// scaled by 4/5 (via two DimensionCalculator_4_5 instances, one per axis)
// until the next level would fall below min_dim or MAX_LEVELS is reached.
// Each level is offered as a descriptor on a valid/ready handshake.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/base_width/base_height/min_dim in,
//                  busy, lvl_valid/lvl_ready, lvl_index/width/height/last,
//                  done pulse, level_count
// ---------------------------------------------------------------------------
module pyramid_level_sequencer
  import pyramid_pkg::*;
#(
  parameter int COORD_BITS = COORD_BITS_DEF,
  parameter int MAX_LEVELS = 16,
  parameter int LEVEL_BITS = LEVEL_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pyramid_level_sequencer_if.slave      bus
);

  // Index 0 is the width axis, index 1 the height axis.
  state_e                state_q, state_d;
  logic [COORD_BITS-1:0] cur_q [2];
  logic [COORD_BITS-1:0] cur_d [2];
  logic [COORD_BITS-1:0] nxt_q [2];
  logic [COORD_BITS-1:0] nxt_d [2];
  logic [1:0]            got_q, got_d;
  logic [COORD_BITS-1:0] min_q, min_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [LEVEL_BITS:0]   count_q, count_d;

  logic                  calc_req;
  logic [1:0]            res_valid;
  logic [COORD_BITS-1:0] res_dim [2];
  logic [COORD_BITS-1:0] min_eff;
  logic                  is_last;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_calc
      DimensionCalculator_4_5 #(.COORD_BITS(COORD_BITS)) u_calc (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (calc_req),
        .in_dim_i    (cur_q[gi]),
        .out_valid_o (res_valid[gi]),
        .out_dim_o   (res_dim[gi])
      );
    end
  endgenerate

  always_comb begin
    min_eff  = (bus.min_dim == '0) ? COORD_BITS'(1) : bus.min_dim;
    is_last  = ({1'b0, level_q} == (LEVEL_BITS+1)'(MAX_LEVELS - 1)) ||
               (nxt_q[0] < min_q) || (nxt_q[1] < min_q);

    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    got_d    = got_q;
    min_d    = min_q;
    level_d  = level_q;
    count_d  = count_q;
    calc_req = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = '0;
          if ((bus.base_width < min_eff) || (bus.base_height < min_eff)) begin
            state_d = ST_FIN;
          end else begin
            cur_d[0] = bus.base_width;
            cur_d[1] = bus.base_height;
            min_d    = min_eff;
            level_d  = '0;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        calc_req = 1'b1;
        got_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Axes may finish in either order or on the same cycle.
        for (int i = 0; i < 2; i++) begin
          if (res_valid[i]) begin
            nxt_d[i] = res_dim[i];
            got_d[i] = 1'b1;
          end
        end
        if (&(got_q | res_valid)) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.lvl_ready) begin
          count_d = count_q + 1'b1;
          if (is_last) begin
            state_d = ST_FIN;
          end else begin
            cur_d   = nxt_q;
            level_d = level_q + 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < 2; i++) begin
        cur_q[i] <= '0;
        nxt_q[i] <= '0;
      end
      got_q   <= '0;
      min_q   <= '0;
      level_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      got_q   <= got_d;
      min_q   <= min_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.lvl_valid   = (state_q == ST_EMIT);
  assign bus.lvl_last    = (state_q == ST_EMIT) && is_last;
  assign bus.lvl_index   = level_q;
  assign bus.lvl_width   = cur_q[0];
  assign bus.lvl_height  = cur_q[1];
  assign bus.done        = (state_q == ST_FIN);
  assign bus.level_count = count_q;

endmodule

// File: tb/tb_pyramid_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pyramid_level_sequencer
// Scoreboard bench: each start pushes the expected level descriptors and the
// expected level_count into queues; monitors pop and compare on every
// handshake / done pulse. A second instance with MAX_LEVELS=4 shares the
// stimulus with lvl_ready tied high.
// ---------------------------------------------------------------------------
module tb_pyramid_level_sequencer;
  import pyramid_pkg::*;

  localparam int CB = 16;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pyramid_level_sequencer_if #(.COORD_BITS(CB), .LEVEL_BITS(LB)) bus ();
  pyramid_level_sequencer_if #(.COORD_BITS(CB), .LEVEL_BITS(LB)) bus4 ();

  pyramid_level_sequencer #(.COORD_BITS(CB), .MAX_LEVELS(16), .LEVEL_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  pyramid_level_sequencer #(.COORD_BITS(CB), .MAX_LEVELS(4), .LEVEL_BITS(LB)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  assign bus4.start       = bus.start;
  assign bus4.base_width  = bus.base_width;
  assign bus4.base_height = bus.base_height;
  assign bus4.min_dim     = bus.min_dim;
  assign bus4.lvl_ready   = 1'b1;

  level_desc_t q16[$];
  level_desc_t q4[$];
  int          dq16[$];
  int          dq4[$];
  int n_chk  = 0;
  int n_pass = 0;
  int rmode  = 0;
  int hold   = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: each level is (prev-1)*4/5+1 per axis; stop at the cap or
  // when the following level would drop below the effective minimum.
  task automatic push_run(int bw, int bh, int m);
    int me;
    me = (m == 0) ? 1 : m;
    for (int k = 0; k < 2; k++) begin
      int maxl, w, h, nw, nh, cnt;
      level_desc_t e;
      maxl = (k == 0) ? 16 : 4;
      w = bw; h = bh; cnt = 0;
      if (w >= me && h >= me) begin
        for (int lv = 0; lv < maxl; lv++) begin
          nw = (w - 1) * 4 / 5 + 1;
          nh = (h - 1) * 4 / 5 + 1;
          e.index  = LB'(lv);
          e.width  = CB'(w);
          e.height = CB'(h);
          e.last   = (lv == maxl - 1) || (nw < me) || (nh < me);
          if (k == 0) q16.push_back(e); else q4.push_back(e);
          cnt++;
          if (e.last) break;
          w = nw; h = nh;
        end
      end
      if (k == 0) dq16.push_back(cnt); else dq4.push_back(cnt);
    end
  endtask

  task automatic pulse_start(int bw, int bh, int m);
    @(posedge clk); #1;
    bus.base_width  = CB'(bw);
    bus.base_height = CB'(bh);
    bus.min_dim     = CB'(m);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  task automatic run(int bw, int bh, int m);
    $display("start %0dx%0d min %0d", bw, bh, m);
    push_run(bw, bh, m);
    pulse_start(bw, bh, m);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus4.busy && q16.size() == 0 && q4.size() == 0 &&
          dq16.size() == 0 && dq4.size() == 0) break;
    end
    if (i == 5000) check("timeout_idle", 0, 1);
  endtask

  // Backpressure driver.
  initial begin
    bus.lvl_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: bus.lvl_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.lvl_valid && bus.lvl_index == 2 && hold < 5) begin
            bus.lvl_ready = 1'b0;
            hold++;
          end else begin
            bus.lvl_ready = 1'b1;
          end
        end
        default: bus.lvl_ready = 1'b1;
      endcase
    end
  end

  // Monitor, main instance.
  level_desc_t e16, p16;
  logic        stall16 = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall16 = 1'b0;
    end else begin
      if (stall16) begin
        check("hold_valid",  int'(bus.lvl_valid),  1);
        check("hold_index",  int'(bus.lvl_index),  int'(p16.index));
        check("hold_width",  int'(bus.lvl_width),  int'(p16.width));
        check("hold_height", int'(bus.lvl_height), int'(p16.height));
        check("hold_last",   int'(bus.lvl_last),   int'(p16.last));
      end
      if (bus.lvl_valid && bus.lvl_ready) begin
        $display("lvl16 idx %0d %0dx%0d last %0d", bus.lvl_index, bus.lvl_width,
                 bus.lvl_height, bus.lvl_last);
        if (q16.size() == 0) begin
          check("unexpected_lvl16", 1, 0);
        end else begin
          e16 = q16.pop_front();
          check("lvl16_index",  int'(bus.lvl_index),  int'(e16.index));
          check("lvl16_width",  int'(bus.lvl_width),  int'(e16.width));
          check("lvl16_height", int'(bus.lvl_height), int'(e16.height));
          check("lvl16_last",   int'(bus.lvl_last),   int'(e16.last));
        end
      end
      if (bus.done) begin
        $display("done16 level_count %0d", bus.level_count);
        if (dq16.size() == 0) check("unexpected_done16", 1, 0);
        else check("done16_count", int'(bus.level_count), dq16.pop_front());
      end
      stall16 = bus.lvl_valid && !bus.lvl_ready;
      p16.index  = bus.lvl_index;
      p16.width  = bus.lvl_width;
      p16.height = bus.lvl_height;
      p16.last   = bus.lvl_last;
    end
  end

  // Monitor, MAX_LEVELS=4 instance.
  level_desc_t e4;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus4.lvl_valid) begin
        $display("lvl4 idx %0d %0dx%0d last %0d", bus4.lvl_index, bus4.lvl_width,
                 bus4.lvl_height, bus4.lvl_last);
        if (q4.size() == 0) begin
          check("unexpected_lvl4", 1, 0);
        end else begin
          e4 = q4.pop_front();
          check("lvl4_index",  int'(bus4.lvl_index),  int'(e4.index));
          check("lvl4_width",  int'(bus4.lvl_width),  int'(e4.width));
          check("lvl4_height", int'(bus4.lvl_height), int'(e4.height));
          check("lvl4_last",   int'(bus4.lvl_last),   int'(e4.last));
        end
      end
      if (bus4.done) begin
        $display("done4 level_count %0d", bus4.level_count);
        if (dq4.size() == 0) check("unexpected_done4", 1, 0);
        else check("done4_count", int'(bus4.level_count), dq4.pop_front());
      end
    end
  end

  initial begin
    int seen;
    bus.start = 1'b0; bus.base_width = '0; bus.base_height = '0; bus.min_dim = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   int'(bus.busy),        0);
    check("rst_valid",  int'(bus.lvl_valid),   0);
    check("rst_last",   int'(bus.lvl_last),    0);
    check("rst_done",   int'(bus.done),        0);
    check("rst_index",  int'(bus.lvl_index),   0);
    check("rst_width",  int'(bus.lvl_width),   0);
    check("rst_height", int'(bus.lvl_height),  0);
    check("rst_count",  int'(bus.level_count), 0);
    check("rst_count4", int'(bus4.level_count), 0);
    @(negedge clk); reset_n = 1'b1;

    run(640, 480, 64); wait_idle();
    check("count_640",  int'(bus.level_count),  10);
    check("count4_640", int'(bus4.level_count), 4);

    rmode = 2; hold = 0;
    run(640, 480, 64); wait_idle();
    rmode = 0;

    run(32, 32, 64); wait_idle();
    check("count_small", int'(bus.level_count), 0);

    run(1, 1, 0); wait_idle();
    check("count_1x1",  int'(bus.level_count),  16);
    check("count4_1x1", int'(bus4.level_count), 4);

    // A start pulse during a run must not disturb it.
    run(640, 480, 64);
    repeat (30) @(posedge clk);
    check("busy_mid_run", int'(bus.busy), 1);
    pulse_start(100, 100, 1);
    wait_idle();

    // Abort in WAIT at level 3.
    run(640, 480, 64);
    seen = 0;
    for (int i = 0; i < 2000 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.lvl_valid && bus.lvl_index == 3) seen++;
      else seen = 0;
    end
    check("reached_wait_l3", seen, 2);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy",  int'(bus.busy),        0);
    check("abort_valid", int'(bus.lvl_valid),   0);
    check("abort_done",  int'(bus.done),        0);
    check("abort_count", int'(bus.level_count), 0);
    q16.delete(); q4.delete(); dq16.delete(); dq4.delete();
    @(negedge clk); reset_n = 1'b1;
    run(640, 480, 64); wait_idle();
    check("count_after_abort", int'(bus.level_count), 10);

    rmode = 1;
    for (int r = 0; r < 25; r++) begin
      int bw, bh, m;
      bw = (r % 6 == 5) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1200));
      bh = int'($urandom_range(0, 1200));
      m  = int'($urandom_range(0, 200));
      run(bw, bh, m); wait_idle();
    end
    rmode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pyramid_level_sequencer.md
PYRAMID_LEVEL_SEQUENCER -- requirements
Module: pyramid_level_sequencer

Interface
REQ-001 Parameter COORD_BITS, default 16, width of every dimension value.
REQ-002 Parameter MAX_LEVELS, default 16, hard cap on levels emitted per run (1..2**LEVEL_BITS).
REQ-003 Parameter LEVEL_BITS, default 4, width of level index; level_count is LEVEL_BITS+1 wide.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a pyramid run; sampled only in IDLE.
REQ-007 base_width, base_height  input  COORD_BITS each  level-0 dimensions, sampled with start.
REQ-008 min_dim  input  COORD_BITS  smallest permitted width/height, sampled with start; 0 treated as 1.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 lvl_valid / lvl_ready  output / input  1 each  valid/ready handshake for level descriptors.
REQ-011 lvl_index, lvl_width, lvl_height, lvl_last  output  LEVEL_BITS / COORD_BITS / COORD_BITS / 1  descriptor of current level.
REQ-012 done  output  1  one-cycle pulse when a run ends; level_count  output  LEVEL_BITS+1  levels emitted that run, held until next start.

Function
REQ-013 Two instances of DimensionCalculator_4_5 (COORD_BITS) compute next = (cur-1)*4/5+1 for width and height; latency is variable, so results are taken only on each instance's out_valid.
REQ-014 States: IDLE, REQ, WAIT, EMIT, FIN.
REQ-015 IDLE + start: if base_width<min_dim or base_height<min_dim (including 0) -> FIN with level_count=0; else cur=base, level=0 -> REQ.
REQ-016 REQ: drive both calculators' in_valid high for exactly one cycle with cur dims -> WAIT.
REQ-017 WAIT: capture each result on its out_valid independently (order and cycle may differ); when both captured -> EMIT.
REQ-018 EMIT: lvl_valid=1, lvl_last = (level==MAX_LEVELS-1) or next_w<min_dim or next_h<min_dim; all lvl_* outputs stable while lvl_ready low.
REQ-019 EMIT with lvl_ready high: level_count+1; if lvl_last -> FIN, else cur=next, level+1 -> REQ.
REQ-020 FIN: done=1 for one cycle -> IDLE; minimum start-to-first-lvl_valid latency is 2 cycles plus calculator latency.
REQ-021 start outside IDLE is ignored; calculator out_valid outside WAIT is ignored.
REQ-022 Dimension 1 maps to 1; MAX_LEVELS alone terminates such runs.
REQ-023 No arithmetic in this block beyond compares and level increment; no overflow possible since next<=cur.

Reset
REQ-024 reset_n low: state IDLE, busy=0, lvl_valid=0, lvl_last=0, done=0, lvl_index/width/height=0, level_count=0, captured flags cleared, immediately and regardless of clk.
REQ-025 Reset mid-run abandons the run without done; a calculator result arriving after reset release is discarded by REQ-021.

Structure
REQ-026 Package pyramid_pkg holds the state enum, default COORD_BITS/LEVEL_BITS constants and a packed level-descriptor struct (index, width, height, last).
REQ-027 Sub-module is DimensionCalculator_4_5, unchanged; no new sub-module.

Verification
REQ-028 start 640x480, min 64, lvl_ready=1 -> 10 levels: 640x480, 512x384, 409x307, 327x245, 261x196, 209x157, 167x125, 133x100, 106x80, 85x64 (last); done; level_count=10.
REQ-029 Same stimulus, MAX_LEVELS=4 -> levels 0..3, lvl_last on 327x245, level_count=4.
REQ-030 Same stimulus, lvl_ready low 5 cycles at level 2 -> 409x307 held stable with lvl_valid high; no level skipped or duplicated.
REQ-031 start 32x32, min 64 -> no lvl_valid, done pulse, level_count=0; base 1x1, min 0 -> 16 levels of 1x1, last at index 15.
REQ-032 reset_n low while in WAIT at level 3, release, start 640x480 -> IDLE immediately, no done for aborted run, new run identical to REQ-028.
REQ-033 start pulsed while busy -> ignored; current run output unchanged.
